// File: rtl/alu_iter.sv
// Integer ALU with iterative (STEP bits per cycle) shifter and a one-cycle done pulse.
// Define ALU_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [11:0]      decinst,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] inm,
  output logic [WIDTH-1:0] SALIDA_Alu,
  output logic             SALIDA_comparativa,
  output logic             carry,
  output logic             sl_ok,
  output logic             busy
);

  localparam int LOGW = $clog2(WIDTH);
  localparam logic [LOGW:0] STEP_N = (LOGW+1)'(STEP);
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_d;
  logic             cmp_d, carry_d, slok_d;
  logic [LOGW:0]    rem_q, rem_d;
  logic             left_q, left_d, arith_q, arith_d;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic                    alt, is_reg, is_imm, supported, is_sub, is_shift, sh_left;
  logic [WIDTH-1:0]        op2, op2_eff;
  logic signed [WIDTH-1:0] op1_s, op2_s;
  logic [WIDTH:0]          sum;
  logic                    slt, sltu;
  logic [LOGW-1:0]         shamt;
  logic [LOGW:0]           step_amt;
  logic                    unused_bits;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic [LOGW:0]    n,
                                                input logic             left,
                                                input logic             arith);
    logic signed [WIDTH-1:0] vs;
    vs = v;
    if (left)       return v << n;
    else if (arith) return $unsigned(vs >>> n);
    else            return v >> n;
  endfunction

  assign opcode      = decinst[6:0];
  assign funct3      = decinst[9:7];
  assign alt         = decinst[10];
  assign unused_bits = decinst[11];

  assign is_reg    = (opcode == OP_REG);
  assign is_imm    = (opcode == OP_IMM);
  assign supported = is_reg | is_imm;
  assign op2       = is_imm ? inm : rs2;
  assign is_sub    = is_reg & alt & (funct3 == 3'b000);
  assign op2_eff   = is_sub ? ~op2 : op2;
  assign sum       = {1'b0, operando1} + {1'b0, op2_eff} + {{WIDTH{1'b0}}, is_sub};
  assign op1_s     = operando1;
  assign op2_s     = op2;
  assign slt       = op1_s < op2_s;
  assign sltu      = operando1 < op2;
  assign shamt     = op2[LOGW-1:0];
  assign sh_left   = (funct3 == 3'b001);
  assign is_shift  = sh_left | (funct3 == 3'b101);
  assign step_amt  = (rem_q < STEP_N) ? rem_q : STEP_N;

  assign busy = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    alu_d   = SALIDA_Alu;
    cmp_d   = SALIDA_comparativa;
    carry_d = carry;
    slok_d  = 1'b0;
    rem_d   = rem_q;
    left_d  = left_q;
    arith_d = arith_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          cmp_d   = 1'b0;
          carry_d = 1'b0;
          slok_d  = 1'b1;
          if (!supported) begin
            alu_d = '0;
          end else if (is_shift) begin
            left_d  = sh_left;
            arith_d = alt;
`ifdef ALU_BARREL_EN
            alu_d = shift_by(operando1, {1'b0, shamt}, sh_left, alt);
`else
            alu_d = operando1;
            if (shamt != '0) begin
              // Result completes in SHIFT; the done pulse comes from the last step
              slok_d  = 1'b0;
              rem_d   = {1'b0, shamt};
              state_d = SHIFT;
            end
`endif
          end else begin
            case (funct3)
              3'b000: begin
                alu_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
              end
              3'b010: begin
                alu_d = {{(WIDTH-1){1'b0}}, slt};
                cmp_d = slt;
              end
              3'b011: begin
                alu_d = {{(WIDTH-1){1'b0}}, sltu};
                cmp_d = sltu;
              end
              3'b100:  alu_d = operando1 ^ op2;
              3'b110:  alu_d = operando1 | op2;
              default: alu_d = operando1 & op2;
            endcase
          end
        end
      end
      SHIFT: begin
        alu_d = shift_by(SALIDA_Alu, step_amt, left_q, arith_q);
        rem_d = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = IDLE;
          slok_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      SALIDA_Alu         <= '0;
      SALIDA_comparativa <= 1'b0;
      carry              <= 1'b0;
      sl_ok              <= 1'b0;
      rem_q              <= '0;
      left_q             <= 1'b0;
      arith_q            <= 1'b0;
    end else begin
      state_q            <= state_d;
      SALIDA_Alu         <= alu_d;
      SALIDA_comparativa <= cmp_d;
      carry              <= carry_d;
      sl_ok              <= slok_d;
      rem_q              <= rem_d;
      left_q             <= left_d;
      arith_q            <= arith_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter: one STEP=1 instance and one STEP=4 instance.
module tb_alu_iter;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        en4 = 1'b0;
  logic [11:0] decinst = '0;
  logic [31:0] operando1 = '0, rs2 = '0, inm = '0;

  logic [31:0] alu1, alu4;
  logic        cmp1, cmp4, c1, c4, ok1, ok4, busy1, busy4;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32), .STEP(1)) dut (
    .clk(clk), .reset(reset), .en(en), .decinst(decinst),
    .operando1(operando1), .rs2(rs2), .inm(inm),
    .SALIDA_Alu(alu1), .SALIDA_comparativa(cmp1), .carry(c1),
    .sl_ok(ok1), .busy(busy1));

  alu_iter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .en(en4), .decinst(decinst),
    .operando1(operando1), .rs2(rs2), .inm(inm),
    .SALIDA_Alu(alu4), .SALIDA_comparativa(cmp4), .carry(c4),
    .sl_ok(ok4), .busy(busy4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic alt,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    decinst   = {1'b0, alt, f3, opc};
    operando1 = a;
    rs2       = b;
    inm       = imm;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({alu1, cmp1, c1, ok1, busy1} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_dut1: got alu=%h cmp=%b c=%b ok=%b busy=%b required all 0", alu1, cmp1, c1, ok1, busy1);
    end
    n_checks++;
    if ({alu4, cmp4, c4, ok4, busy4} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_dut4: got alu=%h cmp=%b c=%b ok=%b busy=%b required all 0", alu4, cmp4, c4, ok4, busy4);
    end
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_addsub;
    set_op(OPR, 3'b000, 1'b1, 32'hC0404040, 32'h00000FFF, 32'h0);
    en = 1'b1;
    tick;
    en = 1'b0;
    n_checks++;
    if (alu1 !== 32'hC0403041 || c1 !== 1'b1 || ok1 !== 1'b1 || cmp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sub: got alu=%h c=%b ok=%b cmp=%b required C0403041 1 1 0", alu1, c1, ok1, cmp1);
    end
    tick;
    n_checks++;
    if (ok1 !== 1'b0 || alu1 !== 32'hC0403041) begin
      n_fail++;
      $display("FAIL sub_hold: got ok=%b alu=%h required 0 C0403041", ok1, alu1);
    end
    set_op(OPR, 3'b000, 1'b0, 32'hC0404040, 32'h00000FFF, 32'h0);
    en = 1'b1;
    tick;
    en = 1'b0;
    n_checks++;
    if (alu1 !== 32'hC040503F || c1 !== 1'b0 || ok1 !== 1'b1) begin
      n_fail++;
      $display("FAIL add: got alu=%h c=%b ok=%b required C040503F 0 1", alu1, c1, ok1);
    end
    // alt on an immediate ADD must still add
    set_op(OPI, 3'b000, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h00000002);
    en = 1'b1;
    tick;
    en = 1'b0;
    n_checks++;
    if (alu1 !== 32'h00000001 || c1 !== 1'b1) begin
      n_fail++;
      $display("FAIL addi_alt: got alu=%h c=%b required 00000001 1", alu1, c1);
    end
  endtask

  task automatic test_compare_logic;
    set_op(OPI, 3'b010, 1'b0, 32'hC0404040, 32'h0, 32'h00000FFF);
    en = 1'b1;
    tick;
    n_checks++;
    if (alu1 !== 32'h1 || cmp1 !== 1'b1 || c1 !== 1'b0) begin
      n_fail++;
      $display("FAIL slti: got alu=%h cmp=%b c=%b required 1 1 0", alu1, cmp1, c1);
    end
    set_op(OPI, 3'b011, 1'b0, 32'hC0404040, 32'h0, 32'h00000FFF);
    tick;
    n_checks++;
    if (alu1 !== 32'h0 || cmp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sltiu: got alu=%h cmp=%b required 0 0", alu1, cmp1);
    end
    set_op(OPR, 3'b011, 1'b0, 32'h00000FFF, 32'hC0404040, 32'h0);
    tick;
    n_checks++;
    if (alu1 !== 32'h1 || cmp1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sltu_reg: got alu=%h cmp=%b required 1 1", alu1, cmp1);
    end
    set_op(OPR, 3'b110, 1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h0);
    tick;
    n_checks++;
    if (alu1 !== 32'h1F3F5F7F || cmp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL or: got alu=%h cmp=%b required 1F3F5F7F 0", alu1, cmp1);
    end
    set_op(OPR, 3'b111, 1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h0);
    tick;
    n_checks++;
    if (alu1 !== 32'h02040608) begin
      n_fail++;
      $display("FAIL and: got alu=%h required 02040608", alu1);
    end
    set_op(7'b0000011, 3'b000, 1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h0);
    tick;
    en = 1'b0;
    n_checks++;
    if (alu1 !== 32'h0 || cmp1 !== 1'b0 || c1 !== 1'b0 || ok1 !== 1'b1) begin
      n_fail++;
      $display("FAIL unsupported: got alu=%h cmp=%b c=%b ok=%b required 0 0 0 1", alu1, cmp1, c1, ok1);
    end
    tick;
  endtask

  task automatic test_shift_iter;
    int cnt, bcnt;
    int exp_cnt;
`ifdef ALU_BARREL_EN
    exp_cnt = 0;
`else
    exp_cnt = 3;
`endif
    set_op(OPR, 3'b101, 1'b1, 32'hC0404040, 32'h00000003, 32'h0);
    en = 1'b1;
    tick;
    en = 1'b0;
    cnt = 0;
    bcnt = 0;
    while (ok1 !== 1'b1 && cnt < 40) begin
      if (busy1 === 1'b1) bcnt++;
      tick;
      cnt++;
    end
    n_checks++;
    if (alu1 !== 32'hF8080808 || ok1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sra_result: got alu=%h ok=%b required F8080808 1", alu1, ok1);
    end
    n_checks++;
    if (cnt != exp_cnt || bcnt != exp_cnt) begin
      n_fail++;
      $display("FAIL sra_timing: got edges=%0d busy=%0d required %0d %0d", cnt, bcnt, exp_cnt, exp_cnt);
    end
    tick;
    n_checks++;
    if (ok1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sra_after: got ok=%b busy=%b required 0 0", ok1, busy1);
    end
    set_op(OPR, 3'b101, 1'b0, 32'h80000000, 32'hFFFFFFE4, 32'h0);
    en = 1'b1;
    tick;
    en = 1'b0;
    cnt = 0;
    while (ok1 !== 1'b1 && cnt < 40) begin
      tick;
      cnt++;
    end
    n_checks++;
    if (alu1 !== 32'h08000000 || ok1 !== 1'b1) begin
      n_fail++;
      $display("FAIL srl_zero_fill: got alu=%h ok=%b required 08000000 1", alu1, ok1);
    end
    tick;
  endtask

  task automatic test_step4_ignore_en;
    int pulses, first_ok;
    int exp_first;
`ifdef ALU_BARREL_EN
    exp_first = 0;
`else
    exp_first = 8;
`endif
    set_op(OPI, 3'b001, 1'b0, 32'h00000001, 32'h0, 32'hFFFFFFFF);
    en4 = 1'b1;
    tick;
    en4 = 1'b0;
    pulses = 0;
    first_ok = -1;
    if (ok4 === 1'b1) begin
      pulses++;
      first_ok = 0;
    end
    set_op(OPR, 3'b000, 1'b0, 32'h5, 32'h6, 32'h0);
    for (int i = 1; i <= 14; i++) begin
`ifndef ALU_BARREL_EN
      en4 = (i >= 2 && i <= 5);
`endif
      tick;
      en4 = 1'b0;
      if (ok4 === 1'b1) begin
        pulses++;
        if (first_ok < 0) first_ok = i;
      end
    end
    n_checks++;
    if (alu4 !== 32'h80000000) begin
      n_fail++;
      $display("FAIL sll4_result: got alu=%h required 80000000", alu4);
    end
    n_checks++;
    if (pulses != 1 || first_ok != exp_first) begin
      n_fail++;
      $display("FAIL sll4_pulses: got pulses=%0d at=%0d required 1 at %0d", pulses, first_ok, exp_first);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    set_op(OPR, 3'b101, 1'b0, 32'hC0404040, 32'd20, 32'h0);
    en = 1'b1;
    tick;
    en = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({alu1, cmp1, c1, ok1, busy1} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got alu=%h cmp=%b c=%b ok=%b busy=%b required all 0", alu1, cmp1, c1, ok1, busy1);
    end
    tick;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (ok1 === 1'b1 || busy1 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d active cycles required 0", pulses);
    end
    set_op(OPR, 3'b000, 1'b0, 32'h1, 32'h1, 32'h0);
    en = 1'b1;
    tick;
    en = 1'b0;
    n_checks++;
    if (alu1 !== 32'h2 || ok1 !== 1'b1 || c1 !== 1'b0) begin
      n_fail++;
      $display("FAIL add_after_reset: got alu=%h ok=%b c=%b required 2 1 0", alu1, ok1, c1);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    set_op(OPR, 3'b000, 1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h0);
    en = 1'b1;
    tick;
    n_checks++;
    if (alu1 !== 32'h21436587 || ok1 !== 1'b1 || c1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_add: got alu=%h ok=%b c=%b required 21436587 1 0", alu1, ok1, c1);
    end
    set_op(OPR, 3'b100, 1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h0);
    tick;
    n_checks++;
    if (alu1 !== 32'h1D3B5977 || ok1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_xor: got alu=%h ok=%b required 1D3B5977 1", alu1, ok1);
    end
    set_op(OPR, 3'b001, 1'b0, 32'h12345678, 32'h00000020, 32'h0);
    tick;
    en = 1'b0;
    n_checks++;
    if (alu1 !== 32'h12345678 || ok1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_sll0: got alu=%h ok=%b busy=%b required 12345678 1 0", alu1, ok1, busy1);
    end
    tick;
    n_checks++;
    if (ok1 !== 1'b0 || alu1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL b2b_end: got ok=%b alu=%h required 0 12345678", ok1, alu1);
    end
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_compare_logic;
    test_shift_iter;
    test_step4_ignore_en;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of 2, >= 8).
REQ-002 SHALL have parameter STEP, default 1, shift bits per cycle in iterative mode (power of 2, 1..WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  operation request, sampled on clk rising edge.
REQ-006 SHALL have port decinst  input  12  decoded instruction: [6:0] opcode (0110011 reg, 0010011 imm), [9:7] funct3, [10] alt (funct7 bit 5), [11] ignored.
REQ-007 SHALL have ports operando1, rs2, inm  input  WIDTH each  operand 1, register operand 2, immediate operand 2.
REQ-008 SHALL have port SALIDA_Alu  output  WIDTH  result register.
REQ-009 SHALL have port SALIDA_comparativa  output  1  compare flag (SLT/SLTU).
REQ-010 SHALL have port carry  output  1  carry-out of ADD / no-borrow of SUB.
REQ-011 SHALL have port sl_ok  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  operation in progress; new en ignored.

Function
REQ-013 Operand 2 SHALL be inm when opcode=0010011, else rs2; any other opcode is unsupported.
REQ-014 funct3 SHALL select: 000 ADD (SUB if alt=1 and reg opcode), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if alt=1), 110 OR, 111 AND.
REQ-015 Shift amount SHALL be operand 2 bits [log2(WIDTH)-1:0]; upper bits ignored.
REQ-016 FSM SHALL have states IDLE and SHIFT; en=1 in IDLE captures operands and decinst at that edge (capture edge).
REQ-017 Non-shift ops and unsupported ops SHALL update outputs at the capture edge, sl_ok=1 for the following cycle only, FSM stays IDLE.
REQ-018 Unsupported ops SHALL yield SALIDA_Alu=0, SALIDA_comparativa=0, carry=0.
REQ-019 ADD/SUB SHALL compute WIDTH+1-bit sum; SUB as op1 + ~op2 + 1; carry = bit WIDTH of that sum; carry=0 for all other ops.
REQ-020 SLT/SLTU SHALL set SALIDA_comparativa = signed/unsigned (op1 < op2) and SALIDA_Alu = zero-extended flag; flag=0 for all other ops.
REQ-021 Shift with amount k=0 SHALL complete like REQ-017 with SALIDA_Alu=op1.
REQ-022 Shift with k>0 SHALL load op1 at capture edge, enter SHIFT, and on each following edge shift by min(STEP, remaining) (SRA sign-fills, SRL/SLL zero-fill).
REQ-023 Final shift edge SHALL be capture edge + ceil(k/STEP); at it FSM returns IDLE and sl_ok=1 for the next cycle only.
REQ-024 busy SHALL be 1 exactly while FSM is SHIFT; en with busy=1 SHALL be ignored and not queued.
REQ-025 SALIDA_Alu SHALL be valid only while sl_ok=1 or idle after completion; outputs hold until next capture edge.
REQ-026 en=1 in the cycle sl_ok=1 SHALL be accepted (back-to-back ops, no bubble).

Reset
REQ-027 reset=1 SHALL immediately force FSM=IDLE, SALIDA_Alu=0, SALIDA_comparativa=0, carry=0, sl_ok=0, busy=0, independent of clk.
REQ-028 reset mid-shift SHALL abort the operation with no sl_ok pulse; first en after reset release is accepted normally.

Configuration
REQ-029 Macro ALU_BARREL_EN defined: shifts SHALL use a single-cycle barrel shifter and complete per REQ-017; SHIFT state, STEP and busy=1 never occur.
REQ-030 ALU_BARREL_EN undefined: shifts SHALL be iterative per REQ-022..REQ-024.

Verification
REQ-031 WIDTH=32: SUB op1=C0404040 rs2=00000FFF -> SALIDA_Alu=C0403041, carry=1, sl_ok one cycle after capture.
REQ-032 ADD reg same operands -> C040503F, carry=0; SLTI op1=C0404040 inm=00000FFF -> SALIDA_Alu=1, SALIDA_comparativa=1; SLTU same -> 0.
REQ-033 STEP=1 SRA op1=C0404040 shamt=3 -> F8080808, busy 3 cycles, sl_ok after capture+3 edges; with ALU_BARREL_EN -> sl_ok after capture edge, busy never 1.
REQ-034 STEP=4 SLL op1=00000001 shamt=31 -> 80000000 after 8 shift edges; en pulses during busy ignored (no extra sl_ok).
REQ-035 reset asserted 2 cycles into SRL shamt=20 -> all outputs 0 immediately, no sl_ok; next ADD 1+1 -> 2.
REQ-036 en held high across ADD then XOR then SLL shamt 0 -> three consecutive sl_ok pulses, results correct each cycle.
